pe_row_param: RTL and testbench
===============================

Name: pe_row_param

Overview:
Parametrised successor to the fixed 8-PE row. A 1-D row of NUM_PE signed multiply lanes computes a sliding-window correlation: NUM_PE preloaded filter weights against the last NUM_PE activation samples. Adds a weight-load sequencer, window-fill tracking, stride decimation, a two-stage pipeline and an output valid flag. Sits between the activation/weight buffers and the psum accumulation stage of the conv/attention datapath.

Parameters:
WIDTH, 8, signed bit width of activations and weights
NUM_PE, 8, lanes/window length (>=2)
STRIDE, 1, output decimation (1..4): one psum per STRIDE accepted samples once the window is full
ACC_W, 2*WIDTH+$clog2(NUM_PE), localparam psum width, not overridable

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
en  in  1  global enable; low freezes every register, including the pipeline
i_w_load  in  1  weight-load strobe
i_f  in  WIDTH  signed weight, sampled when i_w_load
i_clr  in  1  frame restart: empties window, keeps weights
i_valid  in  1  activation strobe
i_r  in  WIDTH  signed activation, sampled when i_valid
o_psum  out  ACC_W  signed window sum
o_valid  out  1  o_psum valid, one-cycle pulse per result
o_err  out  1  sticky: activation arrived while weights incomplete

Behaviour:
- Reset (rst=1 at posedge, any state): weights, window, products and counters go to 0. o_psum=0, o_valid=0, o_err=0. State goes to W_EMPTY. A reset takes effect even when en=0.
- All actions below require en=1. Per-cycle priority: rst > i_clr > i_w_load > i_valid. Lower-priority strobes in the same cycle are dropped.
- States:
  - W_EMPTY: each i_w_load stores i_f as weight f[wcnt] and increments wcnt. When the NUM_PE-th weight is stored, go to FILL. i_valid in this state is dropped and sets o_err.
  - FILL: each i_valid shifts i_r into the window and increments fcnt. The NUM_PE-th sample goes to RUN, and that sample yields the first result (stride phase 0).
  - RUN: each i_valid shifts the window. The stride counter advances modulo STRIDE, and a result is issued on phase 0.
- i_clr in FILL or RUN: go to FILL, clear fcnt, stride phase and window. In-flight pipeline results still complete. i_clr in W_EMPTY is a no-op.
- i_w_load in FILL or RUN: go to W_EMPTY with wcnt=1 and store i_f as f[0]. Window is cleared. In-flight results still complete.
- Arithmetic: psum = sum over j=0..NUM_PE-1 of f[j]*x[t-NUM_PE+1+j]. f[0] is the first weight loaded; x[t] is the newest sample. Signed, full precision, no saturation; ACC_W cannot overflow.
- Pipeline:
  - Stage 1 registers NUM_PE products plus an issue flag.
  - Stage 2 registers the adder-tree sum into o_psum, and o_valid is set.
  - o_valid rises 2 enabled cycles after the accepting edge. o_psum holds its last value while o_valid=0.
  - Back-to-back samples give back-to-back results (STRIDE=1).

Optional Feature:
PE_ROW_PSUM_IN_EN
- Defined: adds input port i_psum (ACC_W, signed). It is sampled in the cycle the stage-1 issue flag is set and added in stage 2, so o_psum = window sum + i_psum. This lets rows chain vertically.
- Undefined: the port is absent and behaviour is exactly as above. Wrap-around in ACC_W on the add is accepted and not flagged.

Decomposition:
- Package definition holds:
  - pe_row_state_e {W_EMPTY, FILL, RUN}
  - function acc_width(width, num_pe)
  - typedefs for signed activation/weight/psum built on the package's width
- Sub-module pe_adder_tree: combinational, NUM_PE signed inputs of 2*WIDTH bits, one ACC_W sum. Purely combinational and not pipelined in this generation.

Test Plan:
- W=8, N=8, S=1. Load weights all 1, stream 1..8 -> o_valid 2 cycles after the 8th sample with o_psum=36. Sample 9 -> next cycle o_psum=44.
- Weights 0..7, stream eight 1s -> 28. Weights all -1 (0xFF), stream eight 127s -> -1016. Weights all -128, stream eight -128s -> 131072.
- STRIDE=2, weights all 1, stream 1..12 -> results 36, 52, 68 only, each after samples 8, 10 and 12.
- Before weights complete, send i_valid -> no output and o_err=1, held through later activity until rst.
- In RUN, pulse i_clr then stream 1..8 -> no output until the 8th new sample, then 36. A result already in flight at the i_clr still appears.
- Hold en=0 for 3 cycles mid-stream -> o_valid and o_psum are frozen, and results resume with the correct values after en rises. Assert rst mid-RUN -> next cycle o_valid=0, o_psum=0, state W_EMPTY.

Source files
------------

// File: rtl/pe_row_param_pkg.sv
// Shared definitions for the parametrised PE row.
//   pe_row_state_e : weight/window sequencer states
//   acc_width()    : psum width for a given sample width and lane count
//   act_t/weight_t/psum_t : signed data types at the package default width
package pe_row_param_pkg;

  localparam int PKG_WIDTH  = 8;
  localparam int PKG_NUM_PE = 8;

  typedef enum logic [1:0] {
    W_EMPTY = 2'd0,
    FILL    = 2'd1,
    RUN     = 2'd2
  } pe_row_state_e;

  // A full-precision product is 2*width bits; summing num_pe of them needs
  // clog2(num_pe) extra bits of headroom.
  function automatic int acc_width(input int width, input int num_pe);
    return 2 * width + $clog2(num_pe);
  endfunction

  localparam int PKG_ACC_W = acc_width(PKG_WIDTH, PKG_NUM_PE);

  typedef logic signed [PKG_WIDTH-1:0] act_t;
  typedef logic signed [PKG_WIDTH-1:0] weight_t;
  typedef logic signed [PKG_ACC_W-1:0] psum_t;

endpackage

// File: rtl/pe_row_param_if.sv
// Bus bundle between the activation/weight buffers and one PE row.
//   en       : global enable
//   i_w_load : weight strobe, i_f : signed weight
//   i_clr    : frame restart
//   i_valid  : activation strobe, i_r : signed activation
//   i_psum   : upstream partial sum (only with PE_ROW_PSUM_IN_EN defined)
//   o_psum   : signed window sum, o_valid : one-cycle result pulse
//   o_err    : sticky activation-before-weights flag
// modport master drives the row, modport slave is the row itself.
interface pe_row_param_if
  import pe_row_param_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_PE = 8
);
  localparam int ACC_W = acc_width(WIDTH, NUM_PE);

  logic                    en;
  logic                    i_w_load;
  logic signed [WIDTH-1:0] i_f;
  logic                    i_clr;
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_r;
`ifdef PE_ROW_PSUM_IN_EN
  logic signed [ACC_W-1:0] i_psum;
`endif
  logic signed [ACC_W-1:0] o_psum;
  logic                    o_valid;
  logic                    o_err;

  modport master (
`ifdef PE_ROW_PSUM_IN_EN
    output i_psum,
`endif
    output en, i_w_load, i_f, i_clr, i_valid, i_r,
    input  o_psum, o_valid, o_err
  );

  modport slave (
`ifdef PE_ROW_PSUM_IN_EN
    input  i_psum,
`endif
    input  en, i_w_load, i_f, i_clr, i_valid, i_r,
    output o_psum, o_valid, o_err
  );

endinterface

// File: rtl/pe_row_param_adder_tree.sv
// pe_adder_tree: purely combinational balanced sum of NUM_PE signed
// 2*WIDTH-bit products into one ACC_W-bit signed result.
//   prod : NUM_PE signed products
//   sum  : signed sum, full precision
module pe_adder_tree
  import pe_row_param_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_PE = 8
) (
  input  logic signed [2*WIDTH-1:0]                 prod [NUM_PE],
  output logic signed [acc_width(WIDTH, NUM_PE)-1:0] sum
);
  localparam int ACC_W  = acc_width(WIDTH, NUM_PE);
  localparam int LEAVES = 1 << $clog2(NUM_PE);

  // Heap-ordered tree: node k sums nodes 2k and 2k+1; leaves beyond NUM_PE
  // are zero so non-power-of-two rows still balance.
  always_comb begin : tree
    logic signed [ACC_W-1:0] node [1:2*LEAVES-1];
    for (int k = 1; k < 2 * LEAVES; k++) node[k] = '0;
    for (int i = 0; i < NUM_PE; i++) node[LEAVES + i] = ACC_W'(prod[i]);
    for (int k = LEAVES - 1; k >= 1; k--) node[k] = node[2*k] + node[2*k+1];
    sum = node[1];
  end

endmodule

// File: rtl/pe_row_param.sv
// pe_row_param: NUM_PE-lane signed sliding-window correlator.
// Weights are loaded serially (first weight pairs with the oldest sample),
// activations shift through a NUM_PE-deep window, and one psum is issued per
// STRIDE accepted samples once the window is full. Two pipeline stages
// follow the window: products, then adder tree into o_psum.
// Ports: clk, rst (synchronous, active-high), bus (pe_row_param_if.slave).
// Optional macro PE_ROW_PSUM_IN_EN adds bus.i_psum, added into o_psum in
// the final stage so rows can be chained.
module pe_row_param
  import pe_row_param_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_PE = 8,
  parameter int STRIDE = 1
) (
  input logic           clk,
  input logic           rst,
  pe_row_param_if.slave bus
);
  localparam int ACC_W  = acc_width(WIDTH, NUM_PE);
  localparam int PROD_W = 2 * WIDTH;
  localparam int WCNT_W = $clog2(NUM_PE + 1);
  localparam int FCNT_W = $clog2(NUM_PE);
  localparam int SPH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  pe_row_state_e     state, state_d;
  logic [WCNT_W-1:0] wcnt, wcnt_d;
  logic [FCNT_W-1:0] fcnt, fcnt_d;
  logic [SPH_W-1:0]  sph, sph_d;
  logic [WCNT_W-1:0] w_idx;
  logic              w_we, win_clr, win_shift, issue, err_set;

  logic signed [WIDTH-1:0]  f   [NUM_PE];
  logic signed [WIDTH-1:0]  win [NUM_PE];  // win[0] oldest, win[NUM_PE-1] newest
  logic                     vld_p0;
  logic signed [PROD_W-1:0] prod_p1 [NUM_PE];
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  psum_p2;
  logic                     vld_p2;
  logic                     err_q;
  logic signed [ACC_W-1:0]  tree_sum;

  function automatic logic [SPH_W-1:0] next_phase(input logic [SPH_W-1:0] p);
    if (int'(p) >= STRIDE - 1) return '0;
    return p + 1'b1;
  endfunction

  pe_adder_tree #(.WIDTH(WIDTH), .NUM_PE(NUM_PE)) u_tree (
    .prod (prod_p1),
    .sum  (tree_sum)
  );

  // Strobe priority: i_clr, then i_w_load, then i_valid. An i_clr in W_EMPTY
  // does nothing but still consumes the cycle.
  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    fcnt_d    = fcnt;
    sph_d     = sph;
    w_we      = 1'b0;
    w_idx     = wcnt;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    issue     = 1'b0;
    err_set   = 1'b0;
    if (bus.i_clr) begin
      if (state != W_EMPTY) begin
        state_d = FILL;
        fcnt_d  = '0;
        sph_d   = '0;
        win_clr = 1'b1;
      end
    end else if (bus.i_w_load) begin
      w_we = 1'b1;
      if (state == W_EMPTY) begin
        wcnt_d = wcnt + 1'b1;
        if (int'(wcnt) == NUM_PE - 1) state_d = FILL;
      end else begin
        // Reload restarts the weight sequence at f[0]
        state_d = W_EMPTY;
        w_idx   = '0;
        wcnt_d  = WCNT_W'(1);
        fcnt_d  = '0;
        sph_d   = '0;
        win_clr = 1'b1;
      end
    end else if (bus.i_valid) begin
      case (state)
        W_EMPTY: err_set = 1'b1;
        FILL: begin
          win_shift = 1'b1;
          if (int'(fcnt) == NUM_PE - 1) begin
            state_d = RUN;
            fcnt_d  = '0;
            issue   = 1'b1;
            sph_d   = next_phase('0);
          end else begin
            fcnt_d = fcnt + 1'b1;
          end
        end
        RUN: begin
          win_shift = 1'b1;
          issue     = (sph == '0);
          sph_d     = next_phase(sph);
        end
        default: state_d = W_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= W_EMPTY;
      wcnt    <= '0;
      fcnt    <= '0;
      sph     <= '0;
      err_q   <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      psum_p2 <= '0;
      for (int j = 0; j < NUM_PE; j++) begin
        f[j]       <= '0;
        win[j]     <= '0;
        prod_p1[j] <= '0;
      end
    end else if (bus.en) begin
      state <= state_d;
      wcnt  <= wcnt_d;
      fcnt  <= fcnt_d;
      sph   <= sph_d;
      if (err_set) err_q <= 1'b1;
      for (int j = 0; j < NUM_PE; j++) begin
        if (w_we && int'(w_idx) == j) f[j] <= bus.i_f;
      end
      // --- window stage: sample accepted, issue flag captured ---
      if (win_clr) begin
        for (int j = 0; j < NUM_PE; j++) win[j] <= '0;
      end else if (win_shift) begin
        for (int j = 0; j < NUM_PE - 1; j++) win[j] <= win[j+1];
        win[NUM_PE-1] <= bus.i_r;
      end
      vld_p0 <= issue;
      // --- stage 1: lane products ---
      for (int j = 0; j < NUM_PE; j++) begin
        prod_p1[j] <= PROD_W'(f[j]) * PROD_W'(win[j]);
      end
      vld_p1 <= vld_p0;
      // --- stage 2: tree sum, held between results ---
      vld_p2 <= vld_p1;
      if (vld_p1) begin
`ifdef PE_ROW_PSUM_IN_EN
        psum_p2 <= tree_sum + bus.i_psum;
`else
        psum_p2 <= tree_sum;
`endif
      end
    end
  end

  assign bus.o_psum  = psum_p2;
  assign bus.o_valid = vld_p2;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_pe_row_param.sv
// Bench for pe_row_param: two rows (STRIDE 1 and 2) share one stimulus
// stream. A queue-based reference model tracks loaded weights, the sample
// history and the two-cycle result latency; it is compared every cycle.
// Table vectors and hand sequences add fixed expected values.
module tb_pe_row_param;
  import pe_row_param_pkg::*;

  localparam int W = 8;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  pe_row_param_if #(.WIDTH(W), .NUM_PE(N)) ifa ();
  pe_row_param_if #(.WIDTH(W), .NUM_PE(N)) ifb ();

  pe_row_param #(.WIDTH(W), .NUM_PE(N), .STRIDE(1)) dut1 (.clk(clk), .rst(rst), .bus(ifa));
  pe_row_param #(.WIDTH(W), .NUM_PE(N), .STRIDE(2)) dut2 (.clk(clk), .rst(rst), .bus(ifb));

  assign ifb.en       = ifa.en;
  assign ifb.i_w_load = ifa.i_w_load;
  assign ifb.i_f      = ifa.i_f;
  assign ifb.i_clr    = ifa.i_clr;
  assign ifb.i_valid  = ifa.i_valid;
  assign ifb.i_r      = ifa.i_r;
`ifdef PE_ROW_PSUM_IN_EN
  assign ifa.i_psum = '0;
  assign ifb.i_psum = '0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int wts[$];
  int hist[$];
  int nacc = 0;
  bit err_m = 1'b0;
  bit pv0 [2] = '{0, 0};
  bit pv1 [2] = '{0, 0};
  int ps0 [2] = '{0, 0};
  int ps1 [2] = '{0, 0};
  bit ov  [2] = '{0, 0};
  int ops [2] = '{0, 0};

  function automatic int stride_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic model_edge();
    bit iss [2];
    int s;
    iss = '{0, 0};
    s = 0;
    if (rst) begin
      wts.delete(); hist.delete(); nacc = 0; err_m = 0;
      for (int k = 0; k < 2; k++) begin
        pv0[k] = 0; pv1[k] = 0; ps0[k] = 0; ps1[k] = 0; ov[k] = 0; ops[k] = 0;
      end
      return;
    end
    if (!ifa.en) return;
    if (ifa.i_clr) begin
      if (wts.size() == N) begin hist.delete(); nacc = 0; end
    end else if (ifa.i_w_load) begin
      if (wts.size() == N) begin wts.delete(); hist.delete(); nacc = 0; end
      wts.push_back(int'($signed(ifa.i_f)));
    end else if (ifa.i_valid) begin
      if (wts.size() < N) err_m = 1;
      else begin
        hist.push_back(int'($signed(ifa.i_r)));
        if (hist.size() > N) void'(hist.pop_front());
        nacc++;
        if (nacc >= N) begin
          for (int j = 0; j < N; j++) s += wts[j] * hist[j];
          for (int k = 0; k < 2; k++) iss[k] = ((nacc - N) % stride_of(k)) == 0;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      ov[k] = pv1[k];
      if (pv1[k]) ops[k] = ps1[k];
      pv1[k] = pv0[k]; ps1[k] = ps0[k];
      pv0[k] = iss[k]; ps0[k] = s;
    end
  endtask

  always @(posedge clk) model_edge();

  always @(negedge clk) begin
    chk("m_valid_s1", ifa.o_valid, ov[0]);
    chk("m_psum_s1", $signed(ifa.o_psum), ops[0]);
    chk("m_err_s1", ifa.o_err, err_m);
    chk("m_valid_s2", ifb.o_valid, ov[1]);
    chk("m_psum_s2", $signed(ifb.o_psum), ops[1]);
    chk("m_err_s2", ifb.o_err, err_m);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(negedge clk); endtask
  task automatic idle(); ifa.i_w_load = 0; ifa.i_clr = 0; ifa.i_valid = 0; endtask
  task automatic do_reset(); idle(); rst = 1; tick(); rst = 0; endtask
  task automatic load_w(input logic [N-1:0][7:0] w);
    for (int j = 0; j < N; j++) begin ifa.i_w_load = 1; ifa.i_f = w[j]; tick(); end
    ifa.i_w_load = 0;
  endtask
  task automatic load_const(input int v, input int cnt);
    for (int j = 0; j < cnt; j++) begin ifa.i_w_load = 1; ifa.i_f = 8'(v); tick(); end
    ifa.i_w_load = 0;
  endtask
  task automatic send(input int v);
    ifa.i_valid = 1; ifa.i_r = 8'(v); tick(); ifa.i_valid = 0;
  endtask

  typedef struct packed {
    logic [N-1:0][7:0] w;
    logic [N-1:0][7:0] x;
    int                exp;
  } vec_t;
  vec_t vt [4];

  int q[$];
  int nv;

  initial begin
    for (int j = 0; j < N; j++) begin
      vt[0].w[j] = 8'd1;   vt[0].x[j] = 8'(j + 1);
      vt[1].w[j] = 8'(j);  vt[1].x[j] = 8'd1;
      vt[2].w[j] = 8'hFF;  vt[2].x[j] = 8'd127;
      vt[3].w[j] = 8'h80;  vt[3].x[j] = 8'h80;
    end
    vt[0].exp = 36; vt[1].exp = 28; vt[2].exp = -1016; vt[3].exp = 131072;

    ifa.en = 1; ifa.i_f = 0; ifa.i_r = 0; idle();
    rst = 1; tick(); rst = 0;
    chk("rst_valid", ifa.o_valid, 0);
    chk("rst_psum", $signed(ifa.o_psum), 0);
    chk("rst_err", ifa.o_err, 0);

    // table vectors: latency and value, both strides
    for (int i = 0; i < 4; i++) begin
      do_reset();
      load_w(vt[i].w);
      for (int j = 0; j < N; j++) send(int'(vt[i].x[j]));
      tick();
      chk("vec_lat1", ifa.o_valid, 0);
      tick();
      chk("vec_valid", ifa.o_valid, 1);
      chk("vec_psum_s1", $signed(ifa.o_psum), vt[i].exp);
      chk("vec_psum_s2", $signed(ifb.o_psum), vt[i].exp);
    end

    // back-to-back results
    do_reset(); load_const(1, N);
    for (int v = 1; v <= 9; v++) send(v);
    tick();
    chk("b2b_first", $signed(ifa.o_psum), 36);
    tick();
    chk("b2b_valid", ifa.o_valid, 1);
    chk("b2b_second", $signed(ifa.o_psum), 44);

    // stride 2 decimation
    do_reset(); load_const(1, N);
    q.delete();
    for (int v = 1; v <= 12; v++) begin send(v); if (ifb.o_valid) q.push_back(int'($signed(ifb.o_psum))); end
    for (int c = 0; c < 3; c++) begin tick(); if (ifb.o_valid) q.push_back(int'($signed(ifb.o_psum))); end
    chk("stride_count", q.size(), 3);
    chk("stride_r0", (q.size() > 0) ? q[0] : -999, 36);
    chk("stride_r1", (q.size() > 1) ? q[1] : -999, 52);
    chk("stride_r2", (q.size() > 2) ? q[2] : -999, 68);

    // sticky error
    do_reset();
    send(5);
    chk("err_set", ifa.o_err, 1);
    chk("err_noout", ifa.o_valid, 0);
    load_const(1, 3); send(4);
    ifa.i_clr = 1; tick(); ifa.i_clr = 0;
    load_const(1, N - 3);
    for (int v = 1; v <= N; v++) send(v);
    tick(); tick();
    chk("err_row_ok", $signed(ifa.o_psum), 36);
    chk("err_held", ifa.o_err, 1);
    do_reset();
    chk("err_rst", ifa.o_err, 0);

    // clear with result in flight
    do_reset(); load_const(1, N);
    for (int v = 1; v <= N; v++) send(v);
    ifa.i_clr = 1; tick(); ifa.i_clr = 0;
    tick();
    chk("clr_inflight_v", ifa.o_valid, 1);
    chk("clr_inflight_p", $signed(ifa.o_psum), 36);
    nv = 0;
    for (int v = 1; v < N; v++) begin send(v); nv += int'(ifa.o_valid); end
    chk("clr_refill_quiet", nv, 0);
    send(N); tick(); tick();
    chk("clr_refill_v", ifa.o_valid, 1);
    chk("clr_refill_p", $signed(ifa.o_psum), 36);

    // enable freeze
    do_reset(); load_const(1, N);
    for (int v = 1; v <= 9; v++) send(v);
    tick();
    ifa.en = 0; ifa.i_valid = 1; ifa.i_r = 8'd100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("frz_valid", ifa.o_valid, 1);
      chk("frz_psum", $signed(ifa.o_psum), 36);
    end
    ifa.en = 1; ifa.i_valid = 0;
    tick();
    chk("frz_resume", $signed(ifa.o_psum), 44);
    send(10); tick(); tick();
    chk("frz_next_v", ifa.o_valid, 1);
    chk("frz_next_p", $signed(ifa.o_psum), 52);

    // reset mid-RUN
    do_reset(); load_const(1, N);
    for (int v = 1; v <= 9; v++) send(v);
    rst = 1; tick(); rst = 0;
    chk("rstrun_valid", ifa.o_valid, 0);
    chk("rstrun_psum", $signed(ifa.o_psum), 0);
    send(3);
    chk("rstrun_wempty", ifa.o_err, 1);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      ifa.en       = ($urandom_range(0, 9) != 0);
      ifa.i_clr    = ($urandom_range(0, 39) == 0);
      ifa.i_w_load = (wts.size() < N) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 79) == 0);
      ifa.i_valid  = ($urandom_range(0, 9) < 7);
      ifa.i_f      = 8'($urandom);
      ifa.i_r      = 8'($urandom);
      tick();
    end
    rst = 0; ifa.en = 1; idle();
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
